// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer and flag controller for an asynchronous FIFO.
//
// Lives in the w_clk domain next to the dual-port FIFO memory. It takes the
// read pointer after the 2-flop synchroniser, still gray-coded. It returns the
// binary write address, the memory write strobe and a registered gray write
// pointer that the read-side synchroniser picks up.
//
// Parameters
//   ADDR_W    memory address width; depth is 2**ADDR_W; pointers are ADDR_W+1 bits
//   AFULL_TH  almost_full threshold on occupancy, 1..2**ADDR_W
//
// Ports
//   w_clk           write-domain clock
//   w_rstn          asynchronous active-low reset
//   w_inc_i         write request from the producer
//   ovf_clr_i       clears the sticky overflow flag
//   sync_rd_ptr_i   synchronised gray read pointer (ADDR_W+1 bits)
//   w_en_o          memory write strobe, w_inc_i & ~full_o (combinational)
//   w_addr_o        binary write address (ADDR_W bits)
//   gray_w_ptr_o    registered gray write pointer (ADDR_W+1 bits)
//   full_o          registered full flag
//   almost_full_o   registered, occupancy >= AFULL_TH
//   w_level_o       registered occupancy seen from the write side, 0..2**ADDR_W
//   overflow_o      sticky, a write was attempted while full
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  input  logic              w_inc_i,
  input  logic              ovf_clr_i,
  input  logic [ADDR_W:0]   sync_rd_ptr_i,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W:0]   gray_w_ptr_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   w_level_o,
  output logic              overflow_o
);

  localparam int unsigned PtrW = ADDR_W + 1;

  logic [PtrW-1:0] w_ptr_q, w_ptr_d;
  logic [PtrW-1:0] gray_q, gray_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic [PtrW-1:0] rd_bin;
  logic [PtrW-1:0] rd_gray_wrapped;

  // A write is taken in the same cycle it is requested unless the FIFO is full.
  assign w_en_o   = w_inc_i & ~full_q;
  assign w_addr_o = w_ptr_q[ADDR_W-1:0];

  // Gray to binary conversion. Each bit is the XOR of itself and all bits above it.
  always_comb begin
    rd_bin = '0;
    rd_bin[PtrW-1] = sync_rd_ptr_i[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      rd_bin[i] = rd_bin[i+1] ^ sync_rd_ptr_i[i];
    end
  end

  // In gray code, "write pointer is exactly one lap ahead" means the top two bits
  // are inverted and the rest are equal.
  assign rd_gray_wrapped = {~sync_rd_ptr_i[ADDR_W:ADDR_W-1], sync_rd_ptr_i[ADDR_W-2:0]};

  always_comb begin
    w_ptr_d = w_ptr_q + {{ADDR_W{1'b0}}, w_en_o};
    // Registering the gray value from the next-state pointer keeps gray_q aligned
    // with w_ptr_q, so it adds no extra cycle of lag.
    gray_d  = w_ptr_d ^ (w_ptr_d >> 1);
    // The read pointer is stale by the synchroniser delay, so this can only
    // over-report occupancy, never under-report it.
    level_d = w_ptr_d - rd_bin;
    full_d  = (gray_d == rd_gray_wrapped);
    afull_d = (level_d >= PtrW'(AFULL_TH));
    // Set has priority over clear, so a clear does not hide an overflow that
    // happens in the same cycle.
    ovf_d   = (w_inc_i & full_q) | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      w_ptr_q <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign gray_w_ptr_o  = gray_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign w_level_o     = level_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl (ADDR_W=3, AFULL_TH=6).
// The bench drives the read pointer in binary and gray-encodes it. A small
// occupancy model queues the expected registered outputs, and each one is
// compared after the next rising edge.
module tb_fifo_wr_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rstn;
  logic       w_inc;
  logic       ovf_clr;
  logic [3:0] sync_rd_ptr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] gray_w_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
  logic       overflow;

  fifo_wr_ctrl #(
    .ADDR_W  (3),
    .AFULL_TH(6)
  ) dut (
    .w_clk        (w_clk),
    .w_rstn       (w_rstn),
    .w_inc_i      (w_inc),
    .ovf_clr_i    (ovf_clr),
    .sync_rd_ptr_i(sync_rd_ptr),
    .w_en_o       (w_en),
    .w_addr_o     (w_addr),
    .gray_w_ptr_o (gray_w_ptr),
    .full_o       (full),
    .almost_full_o(almost_full),
    .w_level_o    (w_level),
    .overflow_o   (overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       ovf;
  } exp_t;

  exp_t       sb_q[$];
  int         n_total = 0;
  int         n_bad   = 0;

  // Model state
  logic [3:0] m_ptr;
  logic       m_full;
  logic       m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gray"}, gray_w_ptr, 0);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_afull"}, almost_full, 0);
    check_eq({tag, "_level"}, w_level, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
    check_eq({tag, "_addr"}, w_addr, 0);
  endtask

  // One cycle. Drive at the falling edge, check the combinational outputs, push
  // the registered expectation, then pop it and compare after the rising edge.
  task automatic step(input logic inc, input logic clr, input logic [3:0] rd_b);
    exp_t       e;
    logic       en;
    logic [3:0] occ;
    logic [3:0] gray_before;
    @(negedge w_clk);
    w_inc       = inc;
    ovf_clr     = clr;
    sync_rd_ptr = rd_b ^ (rd_b >> 1);
    #1;
    en = inc & ~m_full;
    check_eq("w_en", w_en, en);
    check_eq("w_addr", w_addr, m_ptr[2:0]);
    gray_before = gray_w_ptr;
    m_ovf  = (inc & m_full) | (m_ovf & ~clr);
    m_ptr  = m_ptr + 4'(en);
    occ    = m_ptr - rd_b;
    m_full = (occ == 4'd8);
    e.gray  = m_ptr ^ (m_ptr >> 1);
    e.full  = m_full;
    e.afull = (occ >= 4'd6);
    e.level = occ;
    e.ovf   = m_ovf;
    sb_q.push_back(e);
    @(posedge w_clk);
    #1;
    e = sb_q.pop_front();
    check_eq("gray", gray_w_ptr, e.gray);
    check_eq("full", full, e.full);
    check_eq("afull", almost_full, e.afull);
    check_eq("level", w_level, e.level);
    check_eq("ovf", overflow, e.ovf);
    check_eq("gray_step", $countones(gray_w_ptr ^ gray_before), en);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    w_rstn = 1'b1;
    w_inc = 1'b1;
    ovf_clr = 1'b0;
    sync_rd_ptr = '0;
    model_reset();

    // 1. Reset with a write request pending.
    #2 w_rstn = 1'b0;
    #1;
    check_all_zero("rst");
    check_eq("rst_w_en", w_en, 1);
    @(negedge w_clk);
    w_inc = 1'b0;
    @(negedge w_clk);
    w_rstn = 1'b1;

    // 2. Fill to full.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'd0);
      if (i == 5) begin
        check_eq("fill_afull6", almost_full, 1);
        check_eq("fill_level6", w_level, 6);
        check_eq("fill_full6", full, 0);
      end
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_level8", w_level, 8);
    check_eq("fill_gray", gray_w_ptr, 4'b1100);

    // 3. Overflow while full, then clear, then clear racing a new overflow.
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_gray", gray_w_ptr, 4'b1100);
    step(1'b0, 1'b1, 4'd0);
    check_eq("ovf_clr", overflow, 0);
    step(1'b1, 1'b1, 4'd0);
    check_eq("ovf_set_wins", overflow, 1);

    // 4. Reads become visible: read pointer at 3.
    step(1'b0, 1'b0, 4'd3);
    check_eq("drain_full", full, 0);
    check_eq("drain_level", w_level, 5);
    check_eq("drain_afull", almost_full, 0);

    // 5. Wrap-around with the read pointer trailing by two.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, m_ptr - 4'd1);
      check_eq("wrap_level", w_level, 2);
      check_eq("wrap_full", full, 0);
    end

    // 6. Asynchronous reset between edges after five writes.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, m_ptr - 4'd1);
    #2;
    w_inc = 1'b0;
    w_rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    check_eq("midrst_w_en", w_en, 0);
    model_reset();
    @(negedge w_clk);
    sync_rd_ptr = '0;
    w_rstn = 1'b1;
    step(1'b1, 1'b0, 4'd0);
    check_eq("post_rst_gray", gray_w_ptr, 4'b0001);
    check_eq("post_rst_level", w_level, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
